// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the iterative RV32M unit.
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIXUP, ST_DONE} state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_1;
  logic [XLEN-1:0] operand_2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, operand_1, operand_2, input busy, done, result);
  modport slave  (input start, op, operand_1, operand_2, output busy, done, result);
endinterface

// File: rtl/muldiv_addsub.sv
// Combinational W-bit adder/subtractor shared by the multiply and divide iterations.
module muldiv_addsub #(parameter int W = 33) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] full;

  // Subtract as a + ~b + 1; cout=1 then means a >= b (no borrow).
  assign full = {1'b0, a} + {1'b0, sub ? ~b : b} + {{W{1'b0}}, sub};
  assign sum  = full[W-1:0];
  assign cout = full[W];
endmodule

// File: rtl/muldiv_seq.sv
// Radix-2 iterative multiply/divide sequencer: one bit per cycle over a shared add/sub,
// magnitude arithmetic with sign fixup, RISC-V divide special cases short-circuited.
module muldiv_seq
  import muldiv_pkg::*;
#(parameter int XLEN = 32) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] prod;   // {hi: acc/remainder, lo: multiplier/quotient}
  logic [XLEN-1:0]   opb;    // multiplicand or divisor magnitude
  logic              neg_x, neg_r;

  // Start-time decode of signedness, magnitudes and special cases.
  logic            s1, s2, n1, n2, div0, ovf;
  logic [XLEN-1:0] m1, m2, spec_res;

  always_comb begin
    s1       = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
               (bus.op == OP_DIV)  || (bus.op == OP_REM);
    s2       = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    n1       = s1 & bus.operand_1[XLEN-1];
    n2       = s2 & bus.operand_2[XLEN-1];
    m1       = n1 ? -bus.operand_1 : bus.operand_1;
    m2       = n2 ? -bus.operand_2 : bus.operand_2;
    div0     = is_div(bus.op) && (bus.operand_2 == '0);
    ovf      = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.operand_1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.operand_2 == '1);
    spec_res = div0 ? (bus.op[1] ? bus.operand_1 : '1)
                    : (bus.op[1] ? '0 : bus.operand_1);
  end

  logic [XLEN:0] as_a, as_b, as_sum;
  logic          as_cout;

  always_comb begin
    if (is_div(op_q)) as_a = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    else              as_a = {1'b0, prod[2*XLEN-1:XLEN]};
    as_b = {1'b0, opb};
  end

  muldiv_addsub #(.W(XLEN+1)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (is_div(op_q)),
    .sum  (as_sum),
    .cout (as_cout)
  );

  logic [2*XLEN-1:0] prod_full, prod_nxt;
  logic [XLEN-1:0]   fix_res, q_mag, r_mag;

  always_comb begin
    q_mag     = prod[XLEN-1:0];
    r_mag     = prod[2*XLEN-1:XLEN];
    prod_full = neg_x ? -prod : prod;
    if (is_div(op_q))
      fix_res = op_q[1] ? (neg_r ? -r_mag : r_mag) : (neg_x ? -q_mag : q_mag);
    else
      fix_res = (op_q == OP_MUL) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];

    // Restoring divide shifts left with the trial bit; multiply shifts right with carry.
    if (is_div(op_q))
      prod_nxt = as_cout ? {as_sum[XLEN-1:0], prod[XLEN-2:0], 1'b1}
                         : {as_a[XLEN-1:0],   prod[XLEN-2:0], 1'b0};
    else
      prod_nxt = prod[0] ? {as_sum, prod[XLEN-1:1]}
                         : {1'b0, prod[2*XLEN-1:XLEN], prod[XLEN-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      prod       <= '0;
      opb        <= '0;
      neg_x      <= 1'b0;
      neg_r      <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else if (flush) begin
      state    <= ST_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (bus.start) begin
            op_q  <= bus.op;
            neg_x <= n1 ^ n2;
            neg_r <= n1;
            prod  <= {{XLEN{1'b0}}, is_div(bus.op) ? m1 : m2};
            opb   <= is_div(bus.op) ? m2 : m1;
            cnt   <= CW'(XLEN-1);
            if (div0 || ovf) begin
              state      <= ST_DONE;
              bus.result <= spec_res;
              bus.done   <= 1'b1;
            end else begin
              state    <= ST_CALC;
              bus.busy <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          prod <= prod_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          bus.result <= fix_res;
          bus.busy   <= 1'b0;
          bus.done   <= 1'b1;
          state      <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
